// File: rtl/neopix_pkg.sv
// Shared constants and types for the SPI-to-WS2812 bridge.
//   T_BIT / T1H / T0H : WS2812 bit period and high times, in CLOCK_50 cycles
//   T_LATCH           : low time that latches the strip after a frame
//   tx_state_e        : transmitter state encoding
//   spi_pins_t        : raw SPI pin bundle, packed as {ssel, mosi, sck}
package neopix_pkg;

    localparam int T_BIT   = 63;
    localparam int T1H     = 40;
    localparam int T0H     = 20;
    localparam int T_LATCH = 3000;
    localparam int CYC_W   = $clog2(T_LATCH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_BIT = 2'd1,
        LATCH    = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic ssel;
        logic mosi;
        logic sck;
    } spi_pins_t;

    localparam spi_pins_t PINS_IDLE = '{ssel: 1'b1, mosi: 1'b0, sck: 1'b0};

endpackage

// File: rtl/spi_rx_slave.sv
// Write-only SPI mode-0 slave, oversampled in the system clock domain.
//   clk, rst_n   : system clock, async active-low reset
//   pins         : raw {ssel, mosi, sck} from the pads
//   byte_valid   : one-cycle strobe, byte_data holds a completed byte (MSB first)
//   frame_start  : SSEL falling edge (synchronized)
//   frame_end    : SSEL rising edge (synchronized)
module spi_rx_slave
    import neopix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  spi_pins_t  pins,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_start,
    output logic       frame_end
);

    spi_pins_t  s1, s2;
    logic       ssel_d, sck_d;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       sck_rise;

    // Two-flop synchronizer plus one extra sample of SSEL/SCK for edge detection.
    // Reset to the idle pin levels so release from reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= PINS_IDLE;
            s2     <= PINS_IDLE;
            ssel_d <= 1'b1;
            sck_d  <= 1'b0;
        end else begin
            s1     <= pins;
            s2     <= s1;
            ssel_d <= s2.ssel;
            sck_d  <= s2.sck;
        end
    end

    assign frame_start = ssel_d & ~s2.ssel;
    assign frame_end   = ~ssel_d & s2.ssel;

    // SSEL must be low on both samples; an SCK edge landing with SSEL release is dropped.
    assign sck_rise = ~sck_d & s2.sck & ~s2.ssel & ~ssel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (frame_start) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {shift[5:0], s2.mosi};
        end
    end

    // Strobe is combinational so it can never share a cycle with frame_end.
    assign byte_valid = sck_rise & (bit_cnt == 3'd7);
    assign byte_data  = {shift, s2.mosi};

endmodule

// File: rtl/de0_spi_to_neopix.sv
// DE0-Nano top: SPI slave frame in, WS2812 waveform out.
//   CLOCK_50   : 50 MHz system clock
//   KEY[0]     : async active-low reset; KEY[1] unused
//   GPIO_2_IN  : {SSEL, MOSI, SCK}
//   GPIO_2[0]  : WS2812 data; GPIO_2[1] : busy (only with BUSY_OUT_EN); rest 0
// Optional feature macro: BUSY_OUT_EN drives the registered busy flag onto GPIO_2[1].
module de0_spi_to_neopix
    import neopix_pkg::*;
#(
    parameter int NUM_PIXELS = 8
)(
    input  logic        CLOCK_50,
    input  logic [1:0]  KEY,
    input  logic [2:0]  GPIO_2_IN,
    output logic [12:0] GPIO_2
);

    localparam int NUM_BYTES = 3 * NUM_PIXELS;
    localparam int BYTE_W    = $clog2(NUM_BYTES);   // 3N is never a power of two, so 3N fits
    localparam int BIT_W     = BYTE_W + 3;

    logic clk, rst_n, unused_key;
    assign clk        = CLOCK_50;
    assign rst_n      = KEY[0];
    assign unused_key = KEY[1];

    logic       byte_valid, frame_start, frame_end;
    logic [7:0] byte_data;

    spi_rx_slave u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .pins        (spi_pins_t'(GPIO_2_IN)),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    // ---------------- receive side ----------------
    logic [7:0]        buffer [NUM_BYTES];
    logic [BYTE_W-1:0] byte_count, npix;
    logic              rx_active, busy, tx_go, buf_wr;

    assign buf_wr = byte_valid & rx_active & (byte_count < BYTE_W'(NUM_BYTES));
    assign tx_go  = frame_end & rx_active & (byte_count >= BYTE_W'(3));

    always_ff @(posedge clk) begin
        if (buf_wr)
            buffer[byte_count] <= byte_data;
    end

    // A frame is only captured if it opens while the transmitter is idle;
    // otherwise rx_active stays low and the whole frame is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active  <= 1'b0;
            byte_count <= '0;
            npix       <= '0;
        end else begin
            if (frame_start) begin
                rx_active <= ~busy;
                if (!busy)
                    byte_count <= '0;
            end else if (frame_end) begin
                rx_active <= 1'b0;
            end
            if (buf_wr)
                byte_count <= byte_count + 1'b1;
            if (tx_go)
                npix <= BYTE_W'(int'(byte_count) / 3);
        end
    end

    // ---------------- WS2812 transmitter ----------------
    tx_state_e        state, state_nx;
    logic [CYC_W-1:0] cyc_cnt, thr;
    logic [BIT_W-1:0] bit_idx, last_idx;
    logic             bit_end, last_bit, latch_end, cur_bit, data_d, data_q;

    assign last_idx  = BIT_W'(int'(npix) * 24 - 1);
    assign bit_end   = (cyc_cnt == CYC_W'(T_BIT - 1));
    assign last_bit  = (bit_idx == last_idx);
    assign latch_end = (cyc_cnt == CYC_W'(T_LATCH - 1));
    // Bytes go out in received order, MSB first: bit index 7-k within byte.
    assign cur_bit   = buffer[bit_idx[BIT_W-1:3]][~bit_idx[2:0]];
    assign thr       = cur_bit ? CYC_W'(T1H) : CYC_W'(T0H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_nx;
            case (state)
                SEND_BIT: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                LATCH:   cyc_cnt <= cyc_cnt + 1'b1;
                default: begin
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (tx_go)               state_nx = SEND_BIT;
            SEND_BIT: if (bit_end && last_bit) state_nx = LATCH;
            LATCH:    if (latch_end)           state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    always_comb begin
        data_d = 1'b0;
        busy   = 1'b0;
        case (state)
            SEND_BIT: begin
                busy   = 1'b1;
                data_d = (cyc_cnt < thr);
            end
            LATCH:   busy = 1'b1;
            default: ;
        endcase
    end

    // Registered pin driver; async reset forces the line low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= 1'b0;
        else        data_q <= data_d;
    end

    logic busy_pin;
`ifdef BUSY_OUT_EN
    logic busy_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= 1'b0;
        else        busy_q <= busy;
    end
    assign busy_pin = busy_q;
`else
    assign busy_pin = 1'b0;
`endif

    assign GPIO_2 = {11'd0, busy_pin, data_q};

endmodule

// File: tb/tb_de0_spi_to_neopix.sv
`timescale 1ns/1ps
module tb_de0_spi_to_neopix;

    localparam int NPIX = 8;
`ifdef BUSY_OUT_EN
    localparam int BUSY_VIS = 1;
`else
    localparam int BUSY_VIS = 0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic [1:0]  KEY;
    logic [2:0]  GPIO_2_IN;
    logic [12:0] GPIO_2;

    de0_spi_to_neopix #(.NUM_PIXELS(NPIX)) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY       (KEY),
        .GPIO_2_IN (GPIO_2_IN),
        .GPIO_2    (GPIO_2)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_run = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Accepted frame -> list of bits; waveform at time t after the first rise:
    // bit t/63, high while (t%63) < 40 or 20, then 3000 low; busy for the whole span.
    bit         m_bits[$];
    bit         m_active = 0, m_pending = 0, rx_take = 0;
    int         m_t = 0, m_wait = 0;
    logic [7:0] rx_bytes[$];
    logic [7:0] tx_q[$];

    int hi_len[$], rise_cyc[$];
    int hi_run = 0, cyc = 0;

    function automatic void ssel_fall();
        rx_take = !m_active && !m_pending;
        rx_bytes.delete();
    endfunction

    function automatic void ssel_rise();
        int np;
        if (rx_take) begin
            np = rx_bytes.size() / 3;
            if (np > 0) begin
                m_bits.delete();
                for (int j = 0; j < np * 3; j++)
                    for (int k = 7; k >= 0; k--)
                        m_bits.push_back(rx_bytes[j][k]);
                m_pending = 1;
                m_wait    = 0;
            end
        end
        rx_take = 0;
    endfunction

    always @(negedge CLOCK_50) begin
        int nb, ed, eb;
        cyc++;
        if (!KEY[0]) begin
            chk("reset_gpio", int'(GPIO_2), 0);
            m_active  = 0;
            m_pending = 0;
            hi_run    = 0;
        end else begin
            chk("gpio_hi_zero", int'(GPIO_2[12:2]), 0);
            if (!m_active && m_pending && GPIO_2[0]) begin
                chk("first_edge_latency_le8", int'(m_wait <= 8), 1);
                m_pending = 0;
                m_active  = 1;
                m_t       = 0;
            end
            if (m_active) begin
                nb = m_bits.size();
                ed = 0;
                if (m_t < nb * 63)
                    ed = ((m_t % 63) < (m_bits[m_t / 63] ? 40 : 20)) ? 1 : 0;
                eb = BUSY_VIS;
                chk("data_out", int'(GPIO_2[0]), ed);
                chk("busy_out", int'(GPIO_2[1]), eb);
                m_t++;
                if (m_t == nb * 63 + 3000) m_active = 0;
            end else begin
                chk("idle_data", int'(GPIO_2[0]), 0);
                chk("idle_busy", int'(GPIO_2[1]), 0);
                if (m_pending) begin
                    m_wait++;
                    if (m_wait > 16) begin
                        chk("tx_start_timeout", m_wait, 0);
                        m_pending = 0;
                    end
                end
            end
            // pulse-width monitor for the literal checks
            if (GPIO_2[0]) begin
                if (hi_run == 0) rise_cyc.push_back(cyc);
                hi_run++;
            end else if (hi_run > 0) begin
                hi_len.push_back(hi_run);
                hi_run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic spi_frame();
        GPIO_2_IN[2] = 1'b0;
        ssel_fall();
        #1000;
        foreach (tx_q[i]) begin
            for (int k = 7; k >= 0; k--) begin
                GPIO_2_IN[1] = tx_q[i][k];
                #1000 GPIO_2_IN[0] = 1'b1;
                #1000 GPIO_2_IN[0] = 1'b0;
            end
            if (rx_take && rx_bytes.size() < 3 * NPIX) rx_bytes.push_back(tx_q[i]);
        end
        #1000 GPIO_2_IN[2] = 1'b1;
        ssel_rise();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_active || m_pending) && n < 40000) begin
            @(posedge CLOCK_50);
            n++;
        end
        chk(name, int'(!m_active && !m_pending), 1);
        repeat (5) @(posedge CLOCK_50);
        #3;
    endtask

    task automatic new_frame();
        hi_len.delete();
        rise_cyc.delete();
        tx_q.delete();
    endtask

    int exp2[24] = '{20,20,20,20,20,20,20,20,
                     20,40,20,40,20,40,20,40,
                     40,20,40,20,40,20,40,20};

    initial begin
        int n;
        KEY       = 2'b10;
        GPIO_2_IN = 3'b100;
        #53;
        chk("reset_state", int'(GPIO_2), 0);
        KEY = 2'b11;
        #200;

        // frame AA,55,00
        new_frame();
        tx_q = '{8'hAA, 8'h55, 8'h00};
        spi_frame();
        wait_idle("idle_f1");
        chk("f1_pulses", hi_len.size(), 24);
        chk("f1_bit0_high", hi_len[0], 40);
        chk("f1_bit0_low", rise_cyc[1] - rise_cyc[0] - hi_len[0], 23);
        chk("f1_bit1_high", hi_len[1], 20);
        chk("f1_bit1_low", rise_cyc[2] - rise_cyc[1] - hi_len[1], 43);

        // frame 00,55,AA
        #20000;
        new_frame();
        tx_q = '{8'h00, 8'h55, 8'hAA};
        spi_frame();
        wait_idle("idle_f2");
        chk("f2_pulses", hi_len.size(), 24);
        for (int i = 0; i < 24; i++) chk("f2_pattern", hi_len[i], exp2[i]);

        // 4 bytes -> one pixel
        new_frame();
        tx_q = '{8'hAA, 8'h55, 8'h00, 8'hFF};
        spi_frame();
        wait_idle("idle_f3");
        chk("f3_pulses", hi_len.size(), 24);

        // 25 bytes -> 8 pixels, last byte dropped
        new_frame();
        for (int i = 0; i < 24; i++) tx_q.push_back(8'((i * 37 + 5) & 8'hFF));
        tx_q.push_back(8'hFF);
        spi_frame();
        wait_idle("idle_f4");
        chk("f4_pulses", hi_len.size(), 192);

        // frame during busy is ignored
        new_frame();
        tx_q = '{8'h0F, 8'hF0, 8'h3C};
        spi_frame();
        n = 0;
        while (!m_active && n < 100) begin @(posedge CLOCK_50); n++; end
        chk("f5_started", int'(m_active), 1);
        #3;
        tx_q = '{8'hFF, 8'hFF, 8'hFF};
        spi_frame();
        wait_idle("idle_f5");
        chk("f5_pulses", hi_len.size(), 24);
        repeat (300) @(posedge CLOCK_50);
        chk("f5_no_retx", hi_len.size(), 24);

        // reset mid-bit
        new_frame();
        tx_q = '{8'hAA, 8'hAA, 8'hAA};
        spi_frame();
        n = 0;
        while (!(m_active && GPIO_2[0]) && n < 200) begin @(posedge CLOCK_50); n++; end
        chk("f6_high_seen", int'(m_active && GPIO_2[0]), 1);
        #7 KEY = 2'b10;
        #1;
        chk("reset_async_data", int'(GPIO_2[0]), 0);
        chk("reset_async_all", int'(GPIO_2), 0);
        #100 KEY = 2'b11;
        #3000;
        chk("after_reset_quiet", int'(GPIO_2), 0);

        new_frame();
        tx_q = '{8'h55, 8'h00, 8'hFF};
        spi_frame();
        wait_idle("idle_f7");
        chk("f7_pulses", hi_len.size(), 24);
        chk("f7_bit0_high", hi_len[0], 20);
        chk("f7_bit23_high", hi_len[23], 40);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
